// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug command bytes and host-link state encoding
package debug_pkg;

  localparam logic [7:0] CMD_CONT = 8'd99;
  localparam logic [7:0] CMD_STEP = 8'd115;
  localparam logic [7:0] CMD_NEXT = 8'd110;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TX_CMD   = 2'd1;
  localparam logic [1:0] ST_RX_FRAME = 2'd2;
  localparam logic [1:0] ST_STEPPING = 2'd3;

  typedef enum logic {
    MODE_CONT = 1'b0,
    MODE_STEP = 1'b1
  } mode_t;

  // Only the step-mode entry command is answered without a frame.
  function automatic logic cmd_expects_frame(input logic [7:0] cmd);
    return cmd != CMD_STEP;
  endfunction

  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_host_link_snapshot_ram.sv
// rtl/debug_host_link_snapshot_ram.sv - frame snapshot store, sync write, registered read
module snapshot_ram
  import debug_pkg::*;
#(
  parameter int FRAME_BYTES = 8,
  parameter int AW          = addr_bits(FRAME_BYTES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [7:0]    i_raddr,
  output logic [7:0]    o_rdata
);

  localparam logic [8:0] DEPTH = 9'(FRAME_BYTES);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;
  logic       w_rd_ok;

  assign w_rd_ok = {1'b0, i_raddr} < DEPTH;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range reads return zero; same-address collisions return the old byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata <= 8'h00;
    end else begin
      r_rdata <= w_rd_ok ? r_mem[i_raddr[AW-1:0]] : 8'h00;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_host_link.sv
// rtl/debug_host_link.sv - host side of the pipeline debug link: sends commands, captures frames
module debug_host_link
  import debug_pkg::*;
#(
  parameter int FRAME_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        startCont,
  input  logic        startStep,
  input  logic        stepNext,
  input  logic        hostAbort,
  input  logic        txFull,
  output logic        txWrite,
  output logic [7:0]  txData,
  input  logic        rxEmpty,
  input  logic [7:0]  rxData,
  output logic        rxRead,
  input  logic [7:0]  snapAddr,
  output logic [7:0]  snapData,
  output logic        frameValid,
  output logic [15:0] frameCount,
  output logic        stepMode,
  output logic        busy,
  output logic        rxStray,
  output logic        timeoutErr
);

  localparam int          AW        = addr_bits(FRAME_BYTES);
  localparam logic [7:0]  LAST_BYTE = 8'(FRAME_BYTES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

  logic [1:0]  r_state;
  mode_t       r_mode;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_tx_data;
  logic [31:0] r_tmo_cnt;
  logic        r_frame_valid;
  logic [15:0] r_frame_count;
  logic        r_timeout_err;

  logic w_in_rx;
  logic w_tx_write;
  logic w_rx_read;
  logic w_store;
  logic w_last;

  // The RX FIFO is drained in every state so stale bytes never pile up.
  assign w_in_rx    = (r_state == ST_RX_FRAME);
  assign w_tx_write = !reset && (r_state == ST_TX_CMD) && !txFull;
  assign w_rx_read  = !reset && !rxEmpty;
  assign w_store    = w_in_rx && w_rx_read && !hostAbort;
  assign w_last     = (r_byte_cnt == LAST_BYTE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_CONT;
      r_byte_cnt    <= 8'd0;
      r_tx_data     <= 8'd0;
      r_tmo_cnt     <= 32'd0;
      r_frame_valid <= 1'b0;
      r_frame_count <= 16'd0;
      r_timeout_err <= 1'b0;
    end else if (hostAbort) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_CONT;
      r_byte_cnt <= 8'd0;
      r_tmo_cnt  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (startCont) begin
            r_tx_data     <= CMD_CONT;
            r_mode        <= MODE_CONT;
            r_timeout_err <= 1'b0;
            r_state       <= ST_TX_CMD;
          end else if (startStep) begin
            r_tx_data     <= CMD_STEP;
            r_mode        <= MODE_STEP;
            r_timeout_err <= 1'b0;
            r_state       <= ST_TX_CMD;
          end
        end
        ST_TX_CMD: begin
          if (w_tx_write) begin
            if (cmd_expects_frame(r_tx_data)) begin
              r_state       <= ST_RX_FRAME;
              r_byte_cnt    <= 8'd0;
              r_frame_valid <= 1'b0;
              r_tmo_cnt     <= 32'd0;
            end else begin
              r_state <= ST_STEPPING;
            end
          end
        end
        ST_STEPPING: begin
          if (stepNext) begin
            r_tx_data     <= CMD_NEXT;
            r_timeout_err <= 1'b0;
            r_state       <= ST_TX_CMD;
          end
        end
        ST_RX_FRAME: begin
          if (w_rx_read) begin
            r_tmo_cnt <= 32'd0;
            if (w_last) begin
              r_byte_cnt    <= 8'd0;
              r_frame_valid <= 1'b1;
              r_frame_count <= r_frame_count + 16'd1;
              r_state       <= (r_mode == MODE_STEP) ? ST_STEPPING : ST_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end else if (TMO_EN) begin
            if (r_tmo_cnt == TMO_LAST) begin
              r_timeout_err <= 1'b1;
              r_byte_cnt    <= 8'd0;
              r_state       <= ST_IDLE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 32'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  snapshot_ram #(
    .FRAME_BYTES (FRAME_BYTES),
    .AW          (AW)
  ) u_snapshot_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_store),
    .i_waddr (r_byte_cnt[AW-1:0]),
    .i_wdata (rxData),
    .i_raddr (snapAddr),
    .o_rdata (snapData)
  );

  assign txWrite    = w_tx_write;
  assign txData     = r_tx_data;
  assign rxRead     = w_rx_read;
  assign rxStray    = w_rx_read && !w_in_rx;
  assign frameValid = r_frame_valid;
  assign frameCount = r_frame_count;
  assign stepMode   = (r_state == ST_STEPPING);
  assign busy       = (r_state == ST_TX_CMD) || (r_state == ST_RX_FRAME);
  assign timeoutErr = r_timeout_err;

endmodule

// File: tb/tb_debug_host_link.sv
// tb/tb_debug_host_link.sv - randomized scoreboard bench for debug_host_link
module tb_debug_host_link;

  localparam int FB  = 8;
  localparam int TMO = 50;
  localparam logic [7:0] C_CONT = 8'd99;
  localparam logic [7:0] C_STEP = 8'd115;
  localparam logic [7:0] C_NEXT = 8'd110;

  typedef logic [7:0] frame_t [FB];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        startCont = 1'b0, startStep = 1'b0, stepNext = 1'b0, hostAbort = 1'b0;
  logic        txFull = 1'b0, rxEmpty = 1'b1;
  logic [7:0]  rxData = 8'h00, snapAddr = 8'h00;
  logic        txWrite, rxRead, frameValid, stepMode, busy, rxStray, timeoutErr;
  logic [7:0]  txData, snapData;
  logic [15:0] frameCount;

  always #5 clock = ~clock;

  debug_host_link #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .startCont(startCont), .startStep(startStep), .stepNext(stepNext), .hostAbort(hostAbort),
    .txFull(txFull), .txWrite(txWrite), .txData(txData),
    .rxEmpty(rxEmpty), .rxData(rxData), .rxRead(rxRead),
    .snapAddr(snapAddr), .snapData(snapData),
    .frameValid(frameValid), .frameCount(frameCount),
    .stepMode(stepMode), .busy(busy), .rxStray(rxStray), .timeoutErr(timeoutErr)
  );

  int vectors = 0, miscompares = 0;
  logic [7:0] exp_tx [$];
  int         exp_fc [$];
  logic [7:0] rx_q   [$];
  bit pend_pop = 1'b0;
  int cyc_no = 0, pops = 0, last_pop_cyc = 0, tx_seen = 0, stray_seen = 0, last_fc = 0;
  int model_count = 0;
  int tx0, s0, p0, n;
  frame_t fr;

  function automatic void chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // FWFT RX FIFO model: pops decided at the edge, head updated just after the falling edge.
  always @(posedge clock) begin
    cyc_no++;
    if (rxRead) begin
      pend_pop = 1'b1;
      pops++;
      last_pop_cyc = cyc_no;
    end
  end

  always @(negedge clock) begin
    #1;
    if (pend_pop) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pend_pop = 1'b0;
    end
    rxEmpty = (rx_q.size() == 0);
    rxData  = rxEmpty ? 8'h00 : rx_q[0];
  end

  // Monitor: pops expected commands and frame counts as the DUT presents them.
  always @(negedge clock) begin
    #2;
    if (reset) begin
      last_fc = int'(frameCount);
    end else begin
      if (txWrite) begin
        tx_seen++;
        if (exp_tx.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_txWrite: txData=%0d with no command pending", txData);
        end else begin
          chk("txData", txData, exp_tx.pop_front());
        end
      end
      if (rxStray) stray_seen++;
      if (int'(frameCount) != last_fc) begin
        if (exp_fc.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_frame: frameCount=%0d with no frame pending", frameCount);
        end else begin
          chk("frameCount", frameCount, exp_fc.pop_front());
        end
        chk("frameValid_at_done", frameValid, 1);
        last_fc = int'(frameCount);
      end
    end
  end

  task automatic req(input logic [2:0] r);
    {startCont, startStep, stepNext} = r;
    @(negedge clock);
    {startCont, startStep, stepNext} = 3'b000;
  endtask

  task automatic wait_tx(input int target, input string nm);
    int k = 0;
    while (tx_seen < target && k < 200) begin @(negedge clock); #3; k++; end
    chk(nm, tx_seen >= target, 1);
  endtask

  task automatic wait_settle(input logic want_step, input string nm);
    int k = 0;
    do begin @(negedge clock); #2; k++; end
    while ((busy || stepMode !== want_step) && k < 300);
    chk(nm, {busy, stepMode}, {1'b0, want_step});
  endtask

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < FB; i++) f[i] = 8'($urandom);
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < FB; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      rx_q.push_back(f[i]);
    end
  endtask

  task automatic check_snap(input frame_t f);
    logic [7:0] a;
    for (int i = 0; i < FB + 2; i++) begin
      a = (i == FB + 1) ? 8'($urandom_range(200, 255)) : 8'(i);
      snapAddr = a;
      @(negedge clock); #2;
      chk($sformatf("snap[%0d]", a), snapData, (a < FB) ? f[a[2:0]] : 8'h00);
    end
  endtask

  task automatic cont_frame(input frame_t f, input logic [2:0] r, input int full);
    int t;
    t = tx_seen + 1;
    exp_tx.push_back(C_CONT);
    txFull = (full > 0);
    req(r);
    for (int i = 0; i < full; i++) begin
      #2;
      chk("bp_txWrite", txWrite, 0);
      chk("bp_busy", busy, 1);
      @(negedge clock);
    end
    txFull = 1'b0;
    wait_tx(t, "cont_tx");
    @(negedge clock);
    model_count++;
    exp_fc.push_back(model_count & 16'hffff);
    send_frame(f);
    wait_settle(1'b0, "cont_idle");
    chk("cont_frameValid", frameValid, 1);
    chk("cont_timeoutErr", timeoutErr, 0);
    check_snap(f);
  endtask

  task automatic step_session(input int nexts);
    int t;
    frame_t f;
    exp_tx.push_back(C_STEP);
    req(3'b010);
    wait_settle(1'b1, "step_enter");
    req(3'b110);
    #2;
    chk("stepping_ignores_start", {busy, stepMode}, 2'b01);
    for (int k = 0; k < nexts; k++) begin
      t = tx_seen + 1;
      exp_tx.push_back(C_NEXT);
      req(3'b001);
      wait_tx(t, "next_tx");
      @(negedge clock);
      rand_frame(f);
      model_count++;
      exp_fc.push_back(model_count & 16'hffff);
      send_frame(f);
      wait_settle(1'b1, "step_frame_done");
      check_snap(f);
    end
    hostAbort = 1'b1;
    @(negedge clock);
    hostAbort = 1'b0;
    #2;
    chk("step_abort_idle", {busy, stepMode}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_q.push_back(8'h5A);
    repeat (2) @(negedge clock);
    #2;
    chk("rst_txWrite", txWrite, 0);
    chk("rst_rxRead", rxRead, 0);
    chk("rst_rxStray", rxStray, 0);
    chk("rst_txData", txData, 0);
    chk("rst_snapData", snapData, 0);
    chk("rst_frameValid", frameValid, 0);
    chk("rst_frameCount", frameCount, 0);
    chk("rst_timeoutErr", timeoutErr, 0);
    chk("rst_busy_step", {busy, stepMode}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    chk("idle_stray_drain", stray_seen, 1);

    // Continuous run with "01234567"
    for (int i = 0; i < FB; i++) fr[i] = 8'h30 + 8'(i);
    tx0 = tx_seen; s0 = stray_seen;
    cont_frame(fr, 3'b100, 0);
    chk("cont_single_write", tx_seen - tx0, 1);
    chk("cont_frameCount", frameCount, 1);
    chk("cont_no_stray", stray_seen - s0, 0);

    // Step flow: s, n, n
    s0 = stray_seen;
    step_session(2);
    chk("step_frameCount", frameCount, model_count);
    chk("step_no_stray", stray_seen - s0, 0);

    // TX back-pressure for 20 cycles
    tx0 = tx_seen;
    rand_frame(fr);
    cont_frame(fr, 3'b100, 20);
    chk("bp_single_write", tx_seen - tx0, 1);

    // Timeout after 3 bytes
    exp_tx.push_back(C_CONT);
    tx0 = tx_seen + 1;
    req(3'b100);
    wait_tx(tx0, "tmo_tx");
    @(negedge clock);
    for (int i = 0; i < 3; i++) rx_q.push_back(8'($urandom));
    n = 0;
    do begin @(negedge clock); #2; n++; end while (busy && n < 200);
    chk("tmo_idle", {busy, stepMode}, 2'b00);
    chk("tmo_latency", cyc_no - last_pop_cyc, TMO);
    chk("tmo_err", timeoutErr, 1);
    chk("tmo_frameValid", frameValid, 0);
    rand_frame(fr);
    cont_frame(fr, 3'b100, 0);

    // Abort after 4 bytes, then 4 stray bytes
    exp_tx.push_back(C_CONT);
    tx0 = tx_seen + 1;
    req(3'b100);
    wait_tx(tx0, "abort_tx");
    @(negedge clock);
    p0 = pops;
    for (int i = 0; i < 4; i++) rx_q.push_back(8'($urandom));
    n = 0;
    do begin @(negedge clock); #2; n++; end while (pops < p0 + 4 && n < 50);
    chk("abort_pops", pops - p0, 4);
    hostAbort = 1'b1;
    @(negedge clock);
    hostAbort = 1'b0;
    #2;
    chk("abort_idle", {busy, stepMode}, 2'b00);
    s0 = stray_seen;
    for (int i = 0; i < 4; i++) rx_q.push_back(8'($urandom));
    repeat (8) @(negedge clock);
    #2;
    chk("abort_strays", stray_seen - s0, 4);
    chk("abort_frameCount", frameCount, model_count);
    chk("abort_frameValid", frameValid, 0);

    // Priority: startCont beats startStep
    rand_frame(fr);
    cont_frame(fr, 3'b110, 0);

    // Randomized mix of sessions
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        rand_frame(fr);
        cont_frame(fr, ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101, $urandom_range(0, 3));
      end else begin
        step_session($urandom_range(1, 3));
      end
    end

    // Asynchronous reset mid-frame
    exp_tx.push_back(C_CONT);
    tx0 = tx_seen + 1;
    req(3'b100);
    wait_tx(tx0, "arst_tx");
    @(negedge clock);
    rx_q.push_back(8'hA5); rx_q.push_back(8'h3C); rx_q.push_back(8'h77);
    snapAddr = 8'd0;
    repeat (6) @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy_step", {busy, stepMode}, 2'b00);
    chk("arst_frameValid", frameValid, 0);
    chk("arst_frameCount", frameCount, 0);
    chk("arst_timeoutErr", timeoutErr, 0);
    chk("arst_snapData", snapData, 0);
    chk("arst_txData", txData, 0);
    chk("arst_strobes", {txWrite, rxRead, rxStray}, 3'b000);
    model_count = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rand_frame(fr);
    cont_frame(fr, 3'b100, 1);
    chk("post_reset_frameCount", frameCount, 1);

    repeat (3) @(negedge clock);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_fc_drained", exp_fc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
